// File: rtl/gray_counter_n.sv
// rtl/gray_counter_n.sv - up/down Gray counter with binary mirror, terminal flag and independent Gray-to-binary decoder
module gray_counter_n #(
    parameter int WIDTH = 3,   // 2..16
    parameter int WRAP  = 1    // 1: wrap at terminal value, 0: saturate
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             tc,
    input  logic [WIDTH-1:0] dec_in,
    input  logic             dec_vld,
    output logic [WIDTH-1:0] dec_out,
    output logic             dec_vld_out
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MIN_VAL = {WIDTH{1'b0}};

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             tc_q, tc_d;
    logic [WIDTH-1:0] dec_q, dec_d;
    logic             dec_vld_q;

    // Counter next state: load beats counting; tc only marks a step taken at a terminal value
    always_comb begin
        bin_d = bin_q;
        tc_d  = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                if (bin_q == MAX_VAL) begin
                    tc_d  = 1'b1;
                    bin_d = (WRAP != 0) ? MIN_VAL : bin_q;
                end else begin
                    bin_d = bin_q + 1'b1;
                end
            end else begin
                if (bin_q == MIN_VAL) begin
                    tc_d  = 1'b1;
                    bin_d = (WRAP != 0) ? MAX_VAL : bin_q;
                end else begin
                    bin_d = bin_q - 1'b1;
                end
            end
        end
        // Gray is derived from the next binary value so both registers move together
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // Gray-to-binary: bit i is the XOR of all Gray bits from i up to the MSB
    always_comb begin
        dec_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_d[i] = ^(dec_in >> i);
        end
    end

    // Counter state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            tc_q   <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            tc_q   <= tc_d;
        end
    end

    // Decode channel registers; data holds when no valid input
    always_ff @(posedge clk) begin
        if (rst) begin
            dec_q     <= '0;
            dec_vld_q <= 1'b0;
        end else begin
            dec_vld_q <= dec_vld;
            if (dec_vld) begin
                dec_q <= dec_d;
            end
        end
    end

    assign bin         = bin_q;
    assign gray        = gray_q;
    assign tc          = tc_q;
    assign dec_out     = dec_q;
    assign dec_vld_out = dec_vld_q;

endmodule

// File: tb/tb_gray_counter_n.sv
// tb/tb_gray_counter_n.sv - self-checking bench for gray_counter_n (wrap and saturate instances)
module tb_gray_counter_n;

    localparam int W    = 3;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en = 1'b0;
    logic         up = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_bin = '0;
    logic [W-1:0] dec_in = '0;
    logic         dec_vld = 1'b0;

    logic [W-1:0] gray_w, bin_w, dec_w;
    logic         tc_w, dvo_w;
    logic [W-1:0] gray_s, bin_s, dec_s;
    logic         tc_s, dvo_s;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    gray_counter_n #(.WIDTH(W), .WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .gray(gray_w), .bin(bin_w), .tc(tc_w),
        .dec_in(dec_in), .dec_vld(dec_vld), .dec_out(dec_w), .dec_vld_out(dvo_w)
    );

    gray_counter_n #(.WIDTH(W), .WRAP(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_bin(load_bin),
        .gray(gray_s), .bin(bin_s), .tc(tc_s),
        .dec_in(dec_in), .dec_vld(dec_vld), .dec_out(dec_s), .dec_vld_out(dvo_s)
    );

    task automatic chk(input string nm, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Inverse by search: the binary value whose Gray code equals g
    function automatic int gdec(input int g);
        for (int b = 0; b <= MAXV; b++) begin
            if (to_gray(b) == g) return b;
        end
        return -1;
    endfunction

    // Behavioural model; index 0 = wrapping counter, 1 = saturating counter
    int mb[2];
    int mtc[2];
    bit mstep[2];
    int mdec = 0;
    int mdv = 0;
    bit model_ok = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                mb[k] = 0; mtc[k] = 0; mstep[k] = 1'b0;
            end
            mdec = 0; mdv = 0; model_ok = 1'b1;
        end else begin
            for (int k = 0; k < 2; k++) begin
                mstep[k] = 1'b0;
                if (load) begin
                    mb[k] = int'(load_bin); mtc[k] = 0;
                end else if (en) begin
                    if (up && mb[k] == MAXV) begin
                        mtc[k] = 1;
                        if (k == 0) begin mb[k] = 0; mstep[k] = 1'b1; end
                    end else if (!up && mb[k] == 0) begin
                        mtc[k] = 1;
                        if (k == 0) begin mb[k] = MAXV; mstep[k] = 1'b1; end
                    end else begin
                        mb[k] = up ? mb[k] + 1 : mb[k] - 1;
                        mtc[k] = 0; mstep[k] = 1'b1;
                    end
                end else begin
                    mtc[k] = 0;
                end
            end
            mdv = int'(dec_vld);
            if (dec_vld) mdec = gdec(int'(dec_in));
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    int prevg[2] = '{0, 0};
    always @(negedge clk) begin
        int db[2], dg[2], dt[2], dd[2], dv[2];
        db[0] = int'(bin_w);  dg[0] = int'(gray_w); dt[0] = int'(tc_w); dd[0] = int'(dec_w); dv[0] = int'(dvo_w);
        db[1] = int'(bin_s);  dg[1] = int'(gray_s); dt[1] = int'(tc_s); dd[1] = int'(dec_s); dv[1] = int'(dvo_s);
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("bin[%0d]", k), db[k], mb[k]);
                chk($sformatf("gray[%0d]", k), dg[k], to_gray(mb[k]));
                chk($sformatf("tc[%0d]", k), dt[k], mtc[k]);
                chk($sformatf("dec_out[%0d]", k), dd[k], mdec);
                chk($sformatf("dec_vld_out[%0d]", k), dv[k], mdv);
                if (mstep[k]) chk($sformatf("gray_onebit[%0d]", k), $countones(dg[k] ^ prevg[k]), 1);
            end
        end
        prevg[0] = dg[0];
        prevg[1] = dg[1];
    end

    // Apply inputs just after a falling edge, then wait for the next falling edge
    task automatic cyc(input bit r, input bit l, input int lb, input bit e, input bit u,
                       input bit dvl, input int di);
        rst = r; load = l; load_bin = W'(lb); en = e; up = u; dec_vld = dvl; dec_in = W'(di);
        @(negedge clk);
    endtask

    int exp_gray[8] = '{1, 3, 2, 6, 7, 5, 4, 0};

    initial begin
        // Reset
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 5, 1, 1, 1, 3);
        chk("rst_bin", int'(bin_w), 0);
        chk("rst_gray", int'(gray_w), 0);
        chk("rst_tc", int'(tc_w), 0);
        chk("rst_dvo", int'(dvo_w), 0);
        chk("rst_dec", int'(dec_w), 0);

        // Full up sequence with wrap
        for (int i = 0; i < 8; i++) begin
            cyc(0, 0, 0, 1, 1, 0, 0);
            chk($sformatf("up_seq_gray%0d", i), int'(gray_w), exp_gray[i]);
            chk($sformatf("up_seq_tc%0d", i), int'(tc_w), (i == 7) ? 1 : 0);
        end

        // Down from reset wraps to max
        cyc(1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("down_wrap_bin", int'(bin_w), 7);
        chk("down_wrap_gray", int'(gray_w), 4);
        chk("down_wrap_tc", int'(tc_w), 1);
        chk("down_sat_bin", int'(bin_s), 0);
        chk("down_sat_tc", int'(tc_s), 1);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("down2_bin", int'(bin_w), 6);
        chk("down2_gray", int'(gray_w), 5);
        chk("down2_tc", int'(tc_w), 0);

        // Saturate at max
        cyc(0, 1, 7, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 1, 1, 0, 0);
            chk($sformatf("sat_bin%0d", i), int'(bin_s), 7);
            chk($sformatf("sat_gray%0d", i), int'(gray_s), 4);
            chk($sformatf("sat_tc%0d", i), int'(tc_s), 1);
        end
        // en low clears tc and holds
        cyc(0, 0, 0, 0, 1, 0, 0);
        chk("hold_sat_bin", int'(bin_s), 7);
        chk("hold_sat_tc", int'(tc_s), 0);

        // Load wins over count
        cyc(0, 1, 5, 1, 1, 0, 0);
        chk("load_bin", int'(bin_w), 5);
        chk("load_gray", int'(gray_w), 7);
        chk("load_tc", int'(tc_w), 0);

        // Direction change with no dead cycle
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("dir_up", int'(bin_w), 6);
        cyc(0, 0, 0, 1, 0, 0, 0);
        chk("dir_down", int'(bin_w), 5);

        // Decode back-to-back
        cyc(0, 0, 0, 0, 0, 1, 6);
        chk("dec1_out", int'(dec_w), 4);
        chk("dec1_vld", int'(dvo_w), 1);
        cyc(0, 0, 0, 0, 0, 1, 3);
        chk("dec2_out", int'(dec_w), 2);
        chk("dec2_vld", int'(dvo_w), 1);
        cyc(0, 0, 0, 0, 0, 0, 5);
        chk("dec_hold_out", int'(dec_w), 2);
        chk("dec_hold_vld", int'(dvo_w), 0);

        // Reset overrides load mid-count
        cyc(0, 1, 5, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 7);
        chk("pre_rst_bin", int'(bin_w), 6);
        cyc(1, 1, 3, 1, 1, 1, 5);
        chk("rst_ovr_bin", int'(bin_w), 0);
        chk("rst_ovr_gray", int'(gray_w), 0);
        chk("rst_ovr_tc", int'(tc_w), 0);
        chk("rst_ovr_dvo", int'(dvo_w), 0);
        cyc(0, 0, 0, 1, 1, 0, 0);
        chk("post_rst_up", int'(bin_w), 1);

        // Mixed vectors, checked by the model every cycle
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), $urandom_range(0, MAXV),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) < 4),
                $urandom_range(0, 1), $urandom_range(0, MAXV));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/gray_counter_n.md
GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 Parameter WIDTH, default 3: counter and converter width in bits; legal range 2..16.
REQ-002 Parameter WRAP, default 1: 1 = wrap at terminal value, 0 = saturate at terminal value.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; one step per cycle while high.
REQ-006 up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
REQ-007 load  input  1  synchronous load of load_bin.
REQ-008 load_bin  input  WIDTH  binary value to load.
REQ-009 gray  output  WIDTH  registered Gray-coded count.
REQ-010 bin  output  WIDTH  registered binary count.
REQ-011 tc  output  1  registered terminal-count flag.
REQ-012 dec_in  input  WIDTH  Gray value for the independent decode channel.
REQ-013 dec_vld  input  1  dec_in qualifier.
REQ-014 dec_out  output  WIDTH  registered binary decode of dec_in.
REQ-015 dec_vld_out  output  1  dec_out qualifier.

Function
REQ-016 Per-cycle priority SHALL be rst > load > en; en=0 with load=0 holds bin, gray; tc cleared.
REQ-017 load=1 SHALL set bin=load_bin, gray=load_bin ^ (load_bin>>1), tc=0 on the next edge, regardless of en/up.
REQ-018 en=1, up=1, bin<2^WIDTH-1: bin SHALL become bin+1 next cycle, tc=0.
REQ-019 en=1, up=0, bin>0: bin SHALL become bin-1 next cycle, tc=0.
REQ-020 en=1, up=1, bin=2^WIDTH-1: WRAP=1 -> bin=0; WRAP=0 -> bin held; tc=1 next cycle in both cases.
REQ-021 en=1, up=0, bin=0: WRAP=1 -> bin=2^WIDTH-1; WRAP=0 -> bin held; tc=1 next cycle in both cases.
REQ-022 tc SHALL be high only in the cycle following an enabled step taken at a terminal value; held high while saturated and still stepping toward terminal.
REQ-023 gray SHALL equal bin ^ (bin>>1) in every cycle; gray updates in the same cycle as bin (no extra latency).
REQ-024 On every counting step that changes bin (including wrap), gray SHALL differ from its previous value in exactly one bit.
REQ-025 Direction change SHALL take effect on the first enabled cycle with new up value; no dead cycle.
REQ-026 Decode channel: dec_out[WIDTH-1]=dec_in[WIDTH-1]; dec_out[i]=dec_out[i+1]^dec_in[i] for i below; latency exactly 1 cycle.
REQ-027 dec_vld_out SHALL equal dec_vld delayed 1 cycle; dec_out updates only when dec_vld=1, holds otherwise.
REQ-028 Decode channel SHALL be fully independent of counter state, load, en; back-to-back dec_vld every cycle SHALL be supported.

Reset
REQ-029 rst=1 at an edge SHALL force bin=0, gray=0, tc=0, dec_out=0, dec_vld_out=0, overriding load, en, dec_vld.
REQ-030 Reset asserted mid-count SHALL take effect on the next edge; the first enabled step after release SHALL produce bin=1 (up) or bin=2^WIDTH-1 with tc=1 (down, WRAP=1).
REQ-031 No output SHALL be X after the first clock edge with rst=1.

Verification (WIDTH=3)
REQ-032 Reset, then en=1 up=1 for 8 cycles, WRAP=1 -> gray 001,011,010,110,111,101,100,000; tc=1 only with final 000.
REQ-033 From reset, en=1 up=0, WRAP=1 -> bin=111, gray=100, tc=1; next down step -> bin=110, gray=101, tc=0.
REQ-034 WRAP=0, load_bin=111 then en=1 up=1 for 3 cycles -> bin stays 111, gray stays 100, tc=1 all 3 cycles.
REQ-035 load=1, load_bin=101, en=1 up=1 same cycle -> bin=101, gray=111, tc=0 (load wins).
REQ-036 dec_vld=1 with dec_in 110 then 011 on consecutive cycles -> dec_out 100 then 010 on following cycles, dec_vld_out=1 both.
REQ-037 rst=1 asserted while counting at bin=110 with load=1 -> next cycle bin=000, gray=000, tc=0, dec_vld_out=0.
